ddr2buf_rd: RTL and testbench

- Read-side counterpart of the PE-to-DDR write path: issues strided DDR read bursts, accepts the returned read beats and writes each beat into a PE-side on-chip buffer.
- Sits between a DDR read port (address channel plus data channel, both valid/ready) and one buffer write port.
- Driven by a start/done pair from the layer configuration logic.

---
 rtl/ddr2buf_rd_pkg.sv | 16 +
 rtl/ddr2buf_rd_addr_gen.sv | 54 +++++
 rtl/ddr2buf_rd.sv | 152 +++++++++++++++
 tb/tb_ddr2buf_rd.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2buf_rd_pkg.sv
// Shared widths, perf counter width and FSM state encoding for the DDR-to-buffer read path.
package ddr2buf_rd_pkg;

  localparam int DDR_W_DEF      = 512;
  localparam int DDR_ADDR_W_DEF = 32;
  localparam int BURST_W_DEF    = 8;
  localparam int PERF_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/ddr2buf_rd_addr_gen.sv
// Strided read-burst address generator: walks st_addr + k*step for burst_num bursts,
// raising a new request only while the parent grants credit.
module ddr_rd_addr_gen #(
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DDR_ADDR_W-1:0] st_addr,
  input  logic [BURST_W-1:0]    burst,
  input  logic [DDR_ADDR_W-1:0] step,
  input  logic [BURST_W-1:0]    burst_num,
  input  logic                  credit_ok,
  input  logic                  ddr_addr_ready,
  output logic [DDR_ADDR_W-1:0] ddr_addr,
  output logic [BURST_W-1:0]    ddr_size,
  output logic                  ddr_addr_valid,
  output logic                  all_issued
);

  logic [DDR_ADDR_W-1:0] step_r;
  logic [BURST_W-1:0]    remain;
  logic [BURST_W-1:0]    remain_nxt;
  logic                  hs;

  assign hs         = ddr_addr_valid && ddr_addr_ready;
  assign remain_nxt = hs ? remain - BURST_W'(1) : remain;
  assign all_issued = (remain == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr_addr       <= '0;
      ddr_size       <= '0;
      ddr_addr_valid <= 1'b0;
      step_r         <= '0;
      remain         <= '0;
    end else if (start) begin
      ddr_addr       <= st_addr;
      ddr_size       <= burst;
      step_r         <= step;
      remain         <= burst_num;
      ddr_addr_valid <= 1'b1;
    end else begin
      if (hs)
        ddr_addr <= ddr_addr + step_r;
      remain <= remain_nxt;
      // a pending request is never withdrawn; only re-evaluate once it is taken
      if (!ddr_addr_valid || hs)
        ddr_addr_valid <= (remain_nxt != '0) && credit_ok;
    end
  end

endmodule

// File: rtl/ddr2buf_rd.sv
// DDR read bursts into a PE-side buffer. Build option DDR2BUF_PERF_CNT_EN adds
// an address-stall cycle counter on perf_stall_cnt (tied to 0 otherwise).
//   state    | meaning
//   IDLE     | waiting for start, DDR data not accepted
//   RUN      | issuing address requests and accepting beats
//   DRAIN    | all requests issued, accepting remaining beats
//   FIN      | last beat taken; done pulses on the following cycle
module ddr2buf_rd
  import ddr2buf_rd_pkg::*;
#(
  parameter int DDR_W      = DDR_W_DEF,
  parameter int DDR_ADDR_W = DDR_ADDR_W_DEF,
  parameter int BURST_W    = BURST_W_DEF,
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_W     = $clog2(BUF_DEPTH),
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic [DDR_ADDR_W-1:0] conf_st_addr,
  input  logic [BURST_W-1:0]    conf_burst,
  input  logic [DDR_ADDR_W-1:0] conf_step,
  input  logic [BURST_W-1:0]    conf_burst_num,
  input  logic [ADDR_W-1:0]     conf_buf_addr,
  output logic [DDR_ADDR_W-1:0] ddr_addr,
  output logic [BURST_W-1:0]    ddr_size,
  output logic                  ddr_addr_valid,
  input  logic                  ddr_addr_ready,
  input  logic [DDR_W-1:0]      ddr_data,
  input  logic                  ddr_valid,
  output logic                  ddr_ready,
  output logic [ADDR_W-1:0]     buf_wr_addr,
  output logic [DDR_W-1:0]      buf_wr_data,
  output logic                  buf_wr_en,
  output logic [PERF_W-1:0]     perf_stall_cnt
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int TOT_W = 2 * BURST_W;

  state_t             state, state_nxt;
  logic [BURST_W-1:0] burst_r;
  logic [BURST_W-1:0] burst_left;
  logic [TOT_W-1:0]   beats_left;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [OUT_W-1:0]   outst, outst_nxt;
  logic start_ok, zero_xfer, launch, addr_hs, beat_acc;
  logic burst_cmpl, last_beat, credit_ok, all_issued;

  assign start_ok   = start && (state == ST_IDLE);
  assign zero_xfer  = (conf_burst == '0) || (conf_burst_num == '0);
  assign launch     = start_ok && !zero_xfer;
  assign addr_hs    = ddr_addr_valid && ddr_addr_ready;
  assign ddr_ready  = (state == ST_RUN) || (state == ST_DRAIN);
  assign beat_acc   = ddr_valid && ddr_ready;
  assign burst_cmpl = beat_acc && (burst_left == BURST_W'(1));
  assign last_beat  = beat_acc && (beats_left == TOT_W'(1));
  // credit looks at next-cycle occupancy so a freed slot can be reused immediately
  assign outst_nxt  = outst + OUT_W'(addr_hs) - OUT_W'(burst_cmpl);
  assign credit_ok  = (outst_nxt < OUT_W'(MAX_OUTST));

  ddr_rd_addr_gen #(
    .DDR_ADDR_W(DDR_ADDR_W),
    .BURST_W   (BURST_W)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .start         (launch),
    .st_addr       (conf_st_addr),
    .burst         (conf_burst),
    .step          (conf_step),
    .burst_num     (conf_burst_num),
    .credit_ok     (credit_ok),
    .ddr_addr_ready(ddr_addr_ready),
    .ddr_addr      (ddr_addr),
    .ddr_size      (ddr_size),
    .ddr_addr_valid(ddr_addr_valid),
    .all_issued    (all_issued)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = zero_xfer ? ST_FIN : ST_RUN;
      ST_RUN:   if (last_beat) state_nxt = ST_FIN;
                else if (all_issued) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_beat) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_r    <= '0;
      burst_left <= '0;
      beats_left <= '0;
      wr_ptr     <= '0;
      outst      <= '0;
    end else if (launch) begin
      burst_r    <= conf_burst;
      burst_left <= conf_burst;
      beats_left <= TOT_W'(conf_burst) * TOT_W'(conf_burst_num);
      wr_ptr     <= conf_buf_addr;
      outst      <= '0;
    end else begin
      outst <= outst_nxt;
      if (beat_acc) begin
        burst_left <= burst_cmpl ? burst_r : burst_left - BURST_W'(1);
        beats_left <= beats_left - TOT_W'(1);
        wr_ptr     <= (wr_ptr == ADDR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      done        <= 1'b0;
    end else begin
      buf_wr_en <= beat_acc;
      if (beat_acc) begin
        buf_wr_addr <= wr_ptr;
        buf_wr_data <= ddr_data;
      end
      done <= (state == ST_FIN);
    end
  end

`ifdef DDR2BUF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_stall_cnt <= '0;
    else if (start_ok)
      perf_stall_cnt <= '0;
    else if (ddr_addr_valid && !ddr_addr_ready && (perf_stall_cnt != '1))
      perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
  end
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr2buf_rd.sv
// Directed bench for ddr2buf_rd: table of transfers plus hand sequences for
// stalls, credit limiting, ignored start and mid-transfer reset.
module tb_ddr2buf_rd;

  localparam int DW = 512;

  logic            clk, rst, start, done;
  logic [31:0]     conf_st_addr, conf_step;
  logic [7:0]      conf_burst, conf_burst_num, conf_buf_addr;
  logic [31:0]     ddr_addr;
  logic [7:0]      ddr_size;
  logic            ddr_addr_valid, ddr_addr_ready;
  logic [DW-1:0]   ddr_data;
  logic            ddr_valid, ddr_ready;
  logic [7:0]      buf_wr_addr;
  logic [DW-1:0]   buf_wr_data;
  logic            buf_wr_en;
  logic [15:0]     perf_stall_cnt;

  ddr2buf_rd dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .conf_st_addr(conf_st_addr), .conf_burst(conf_burst), .conf_step(conf_step),
    .conf_burst_num(conf_burst_num), .conf_buf_addr(conf_buf_addr),
    .ddr_addr(ddr_addr), .ddr_size(ddr_size), .ddr_addr_valid(ddr_addr_valid),
    .ddr_addr_ready(ddr_addr_ready), .ddr_data(ddr_data), .ddr_valid(ddr_valid),
    .ddr_ready(ddr_ready), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_wr_en(buf_wr_en), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [31:0] a, input int j);
    return {16{a + 32'(j)}};
  endfunction

  // transfer model and observation state
  logic [31:0]   m_st, m_step;
  logic [7:0]    m_burst, m_buf;
  logic [31:0]   hs_addr[$];
  logic [7:0]    hs_size[$];
  logic [31:0]   pend_addr[$];
  int            pend_size[$];
  int            pend_beat = 0;
  int            beats_allowed = 1000000;
  bit            stray = 1'b0;
  int            stray_acc = 0;
  logic [DW-1:0] exp_wdata[$];
  int            wr_cnt = 0, last_wr_cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  logic [7:0]    first_wr, last_wr;
  logic [15:0]   perf_at_done;

  // DDR model: drives data at negedge+1, decides handshakes at negedge+2
  initial begin
    ddr_valid = 1'b0;
    ddr_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      ddr_valid = 1'b0;
      ddr_data  = '0;
      if (stray) begin
        ddr_valid = 1'b1;
        ddr_data  = {16{32'hDEADBEEF}};
      end else if (beats_allowed > 0 && pend_addr.size() > 0) begin
        ddr_valid = 1'b1;
        ddr_data  = beat_data(pend_addr[0], pend_beat);
      end
      #1;
      if (ddr_valid && ddr_ready) begin
        if (stray) stray_acc++;
        else begin
          exp_wdata.push_back(ddr_data);
          beats_allowed--;
          pend_beat++;
          if (pend_beat == pend_size[0]) begin
            void'(pend_addr.pop_front());
            void'(pend_size.pop_front());
            pend_beat = 0;
          end
        end
      end
      if (ddr_addr_valid && ddr_addr_ready) begin
        hs_addr.push_back(ddr_addr);
        hs_size.push_back(ddr_size);
        pend_addr.push_back(ddr_addr);
        pend_size.push_back(int'(ddr_size));
      end
    end
  end

  // buffer-side monitor
  initial begin
    logic [7:0]    ea;
    logic [DW-1:0] ed;
    forever begin
      @(negedge clk);
      if (buf_wr_en) begin
        ea = m_buf + 8'(wr_cnt);
        chk("wr_addr", 32'(buf_wr_addr), 32'(ea));
        if (exp_wdata.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_unexpected: write at addr 0x%0h, required no write", buf_wr_addr);
        end else begin
          ed = exp_wdata.pop_front();
          tests++;
          if (buf_wr_data !== ed) begin
            fails++;
            $display("FAIL wr_data: got 0x%0h, expected 0x%0h (low word)", buf_wr_data[31:0], ed[31:0]);
          end
        end
        if (wr_cnt == 0) first_wr = buf_wr_addr;
        last_wr     = buf_wr_addr;
        last_wr_cyc = cyc;
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        perf_at_done = perf_stall_cnt;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] st, input logic [7:0] b, input logic [31:0] stp,
                            input logic [7:0] n, input logic [7:0] ba);
    @(negedge clk);
    conf_st_addr = st; conf_burst = b; conf_step = stp; conf_burst_num = n; conf_buf_addr = ba;
    m_st = st; m_burst = b; m_step = stp; m_buf = ba;
    hs_addr.delete(); hs_size.delete();
    wr_cnt = 0; done_cnt = 0;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); #3;
      n++;
    end
    chk("done_timeout", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_xfer(input int e_hs, input int e_wr, input logic [7:0] e_first,
                            input logic [7:0] e_last, input logic [31:0] e_last_ddr,
                            input logic [15:0] e_perf);
    repeat (3) @(negedge clk);
    #3;
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("hs_count", 32'(hs_addr.size()), 32'(e_hs));
    for (int k = 0; k < hs_addr.size(); k++) begin
      chk("burst_addr", hs_addr[k], m_st + 32'(k) * m_step);
      chk("burst_size", 32'(hs_size[k]), 32'(m_burst));
    end
    chk("wr_count", 32'(wr_cnt), 32'(e_wr));
    chk("perf_at_done", 32'(perf_at_done), 32'(e_perf));
    if (e_wr > 0) begin
      chk("first_wr_addr", 32'(first_wr), 32'(e_first));
      chk("last_wr_addr", 32'(last_wr), 32'(e_last));
      chk("done_after_last_wr", 32'(done_cyc - last_wr_cyc), 32'd1);
      chk("last_ddr_addr", hs_addr[hs_addr.size()-1], e_last_ddr);
    end else begin
      chk("zero_done_latency", 32'(done_cyc - start_cyc), 32'd2);
    end
    chk("leftover_beats", 32'(exp_wdata.size() + pend_addr.size()), 32'd0);
  endtask

  typedef struct {
    logic [31:0] st;
    logic [7:0]  burst;
    logic [31:0] step;
    logic [7:0]  num;
    logic [7:0]  bufa;
    int          e_hs;
    int          e_wr;
    logic [7:0]  e_first;
    logic [7:0]  e_last;
    logic [31:0] e_last_ddr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a0;
    logic [7:0]  s0;
    logic [15:0] e_stall;
    int          n;

    vecs[0] = '{32'h0000_1000, 8'd4, 32'h40,  8'd3, 8'd0,   3, 12, 8'd0,   8'd11,  32'h0000_1080};
    vecs[1] = '{32'h0000_0000, 8'd8, 32'h100, 8'd1, 8'd250, 1, 8,  8'd250, 8'd1,   32'h0000_0000};
    vecs[2] = '{32'h0000_2000, 8'd2, 32'h20,  8'd2, 8'd10,  2, 4,  8'd10,  8'd13,  32'h0000_2020};
    vecs[3] = '{32'hFFFF_FFC0, 8'd1, 32'h40,  8'd3, 8'd5,   3, 3,  8'd5,   8'd7,   32'h0000_0040};
    vecs[4] = '{32'h0000_0100, 8'd0, 32'h10,  8'd3, 8'd0,   0, 0,  8'd0,   8'd0,   32'h0};
    vecs[5] = '{32'h0000_0100, 8'd3, 32'h10,  8'd0, 8'd0,   0, 0,  8'd0,   8'd0,   32'h0};
    vecs[6] = '{32'h0000_3000, 8'd1, 32'h8,   8'd6, 8'd100, 6, 6,  8'd100, 8'd105, 32'h0000_3028};

    rst = 1'b1; start = 1'b0;
    conf_st_addr = '0; conf_step = '0; conf_burst = '0; conf_burst_num = '0; conf_buf_addr = '0;
    ddr_addr_ready = 1'b1;
    m_st = '0; m_step = '0; m_burst = '0; m_buf = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr_valid", 32'(ddr_addr_valid), 32'd0);
    chk("rst_ddr_ready", 32'(ddr_ready), 32'd0);
    chk("rst_wr_en", 32'(buf_wr_en), 32'd0);
    chk("rst_perf", 32'(perf_stall_cnt), 32'd0);
    chk("rst_ddr_addr", ddr_addr, 32'd0);
    chk("rst_ddr_size", 32'(ddr_size), 32'd0);
    chk("rst_wr_addr", 32'(buf_wr_addr), 32'd0);
    chk("rst_wr_data_nz", 32'(buf_wr_data != '0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // beats offered while idle must be refused
    @(negedge clk);
    stray = 1'b1;
    repeat (4) begin
      @(negedge clk); #3;
      chk("idle_ddr_ready", 32'(ddr_ready), 32'd0);
    end
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("idle_beats_taken", 32'(stray_acc), 32'd0);
    chk("idle_writes", 32'(wr_cnt), 32'd0);

    for (int i = 0; i < 7; i++) begin
      start_xfer(vecs[i].st, vecs[i].burst, vecs[i].step, vecs[i].num, vecs[i].bufa);
      wait_done(300);
      check_xfer(vecs[i].e_hs, vecs[i].e_wr, vecs[i].e_first, vecs[i].e_last,
                 vecs[i].e_last_ddr, 16'd0);
    end

    // first request held off for five cycles
    @(negedge clk);
    ddr_addr_ready = 1'b0;
    start_xfer(32'h1000, 8'd4, 32'h40, 8'd3, 8'd0);
    n = 0;
    while (!ddr_addr_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", 32'(ddr_addr_valid), 32'd1);
    a0 = ddr_addr;
    s0 = ddr_size;
    chk("stall_first_addr", a0, 32'h1000);
    repeat (4) begin
      @(negedge clk);
      chk("stall_addr_stable", ddr_addr, a0);
      chk("stall_size_stable", 32'(ddr_size), 32'(s0));
      chk("stall_valid_held", 32'(ddr_addr_valid), 32'd1);
    end
    @(negedge clk);
    ddr_addr_ready = 1'b1;
    wait_done(300);
`ifdef DDR2BUF_PERF_CNT_EN
    e_stall = 16'd5;
`else
    e_stall = 16'd0;
`endif
    check_xfer(3, 12, 8'd0, 8'd11, 32'h1080, e_stall);

    // credit limit: four bursts in flight, then one burst of data frees one slot
    @(negedge clk);
    beats_allowed = 0;
    start_xfer(32'h9000, 8'd2, 32'h80, 8'd8, 8'd40);
    repeat (20) @(negedge clk);
    #3;
    chk("credit_hs_4", 32'(hs_addr.size()), 32'd4);
    chk("credit_valid_low", 32'(ddr_addr_valid), 32'd0);
    @(negedge clk);
    beats_allowed = 2;
    repeat (8) @(negedge clk);
    #3;
    chk("credit_hs_5", 32'(hs_addr.size()), 32'd5);
    chk("credit_valid_low2", 32'(ddr_addr_valid), 32'd0);
    @(negedge clk);
    beats_allowed = 1000000;
    wait_done(400);
    check_xfer(8, 16, 8'd40, 8'd55, 32'h9380, 16'd0);

    // a start while running must not re-latch the configuration
    start_xfer(32'h5000, 8'd2, 32'h10, 8'd3, 8'd20);
    repeat (2) @(negedge clk);
    conf_st_addr = 32'hAAAA_0000; conf_burst = 8'd5; conf_step = 32'h4;
    conf_burst_num = 8'd7; conf_buf_addr = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300);
    check_xfer(3, 6, 8'd20, 8'd25, 32'h5020, 16'd0);

    // reset while draining
    @(negedge clk);
    beats_allowed = 0;
    start_xfer(32'h7000, 8'd4, 32'h100, 8'd2, 8'd0);
    repeat (10) @(negedge clk);
    #3;
    chk("drain_hs", 32'(hs_addr.size()), 32'd2);
    chk("drain_ddr_ready", 32'(ddr_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ddr_ready", 32'(ddr_ready), 32'd0);
    chk("mid_rst_addr_valid", 32'(ddr_addr_valid), 32'd0);
    chk("mid_rst_ddr_addr", ddr_addr, 32'd0);
    chk("mid_rst_ddr_size", 32'(ddr_size), 32'd0);
    chk("mid_rst_wr_en", 32'(buf_wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(buf_wr_addr), 32'd0);
    chk("mid_rst_wr_data_nz", 32'(buf_wr_data != '0), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_perf", 32'(perf_stall_cnt), 32'd0);
    pend_addr.delete(); pend_size.delete(); exp_wdata.delete();
    pend_beat = 0;
    @(negedge clk);
    rst = 1'b0;
    beats_allowed = 1000000;
    start_xfer(32'h8000, 8'd2, 32'h40, 8'd2, 8'd30);
    wait_done(300);
    check_xfer(2, 4, 8'd30, 8'd33, 32'h8040, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
